// File: rtl/gray_ptr_if.sv
//==============================================================================
// Module  : gray_ptr_if
// Brief   : Pointer-side bus of a Gray-code FIFO pointer (requests, remote
//           pointer in, local pointer/status out).
// Revision: 1.0  initial release
//==============================================================================
`default_nettype none

interface gray_ptr_if #(
  parameter int AW = 8
);
  logic          inc;
  logic [AW:0]   rgray;
  logic [AW:0]   bin;
  logic [AW:0]   gray;
  logic [AW-1:0] addr;
  logic          flag;
  logic          err;
  logic [AW:0]   level;

  modport master (
    output inc, rgray,
    input  bin, gray, addr, flag, err, level
  );

  modport slave (
    input  inc, rgray,
    output bin, gray, addr, flag, err, level
  );
endinterface

`default_nettype wire

// File: rtl/gray_ptr.sv
//==============================================================================
// Module  : gray_ptr
// Brief   : One side of an async FIFO: binary/Gray pointer, full (MODE 0) or
//           empty (MODE 1) flag, sticky reject error, optional occupancy.
// Macro   : GRAY_PTR_LEVEL_EN builds the occupancy (level) logic.
// Revision: 1.0  initial release
//==============================================================================
`default_nettype none

module gray_ptr #(
  parameter int AW   = 8,
  parameter int MODE = 0
) (
  input  wire logic   clk,
  input  wire logic   rst,
  gray_ptr_if.slave   bus
);

  logic [AW:0] bin_q,  bin_d;
  logic [AW:0] gray_q, gray_d;
  logic        flag_q, flag_d;
  logic        err_q,  err_d;

  always_comb begin
    bin_d = bin_q;
    if (bus.inc && !flag_q) begin
      bin_d = bin_q + 1'b1;
    end
    // Gray comes from the next-state binary so both registers load together.
    gray_d = bin_d ^ (bin_d >> 1);
    err_d  = err_q | (bus.inc & flag_q);
  end

  generate
    if (MODE == 0) begin : g_full
      always_comb flag_d = (gray_d == {~bus.rgray[AW:AW-1], bus.rgray[AW-2:0]});
    end else begin : g_empty
      always_comb flag_d = (gray_d == bus.rgray);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      gray_q <= '0;
      flag_q <= (MODE != 0);
      err_q  <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      flag_q <= flag_d;
      err_q  <= err_d;
    end
  end

`ifdef GRAY_PTR_LEVEL_EN
  logic [AW:0] rbin;
  logic [AW:0] level_q, level_d;

  always_comb begin
    for (int i = 0; i <= AW; i++) begin
      rbin[i] = ^(bus.rgray >> i);
    end
    level_d = (MODE == 0) ? (bin_d - rbin) : (rbin - bin_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  assign bus.level = level_q;
`else
  assign bus.level = '0;
`endif

  assign bus.bin  = bin_q;
  assign bus.gray = gray_q;
  assign bus.addr = bin_q[AW-1:0];
  assign bus.flag = flag_q;
  assign bus.err  = err_q;

endmodule

`default_nettype wire
